writeback_unit: RTL and testbench
=================================

# writeback_unit

Final pipeline stage of the core, directly upstream of the register file. It drives the register file's write-side inputs: `RegWrite`, `UART_write_enable`, `distinct`, `AorF_before`, `rw` and `write_data`. Results from execute/memory are registered and forwarded as one-cycle write pulses, with a toggling `distinct` token so each result writes exactly once. A UART receive path buffers incoming bytes and, on an `in` instruction, assembles four bytes into a 32-bit word and writes it to an integer or float register.

## Interface
Parameters:
- `RX_DEPTH`, 8, byte FIFO depth (power of two, ≥4)

Ports:
- `CLK` in 1: clock
- `reset` in 1: reset, synchronous, active-high
- `ex_valid` in 1: result available this cycle
- `ex_reg_write` in 1: result targets a register
- `ex_is_float` in 1: 1 = f-file, 0 = r-file
- `ex_rw` in 5: destination register
- `ex_data` in 32: result value
- `rx_valid` in 1: UART byte strobe
- `rx_byte` in 8: received byte
- `in_req` in 1: `in` instruction issued (one-cycle pulse)
- `in_rw` in 5: `in` destination register
- `in_is_float` in 1: `in` targets the f-file
- `wb_reg_write` out 1: to `RegWrite`
- `wb_uart_we` out 1: to `UART_write_enable`
- `wb_distinct` out 1: to `distinct`
- `wb_aorf` out 1: to `AorF_before`
- `wb_rw` out 5: to `rw`
- `wb_data` out 32: to `write_data`
- `stall` out 1: upstream must hold; high whenever FSM ≠ IDLE
- `in_done` out 1: one-cycle pulse when the `in` word is written
- `rx_overflow` out 1: sticky, a byte was dropped

## Operation
- **Reset values:** all outputs 0; FSM in IDLE; FIFO empty; byte counter 0; token 0.
- **Result path:**
  - `ex_valid && ex_reg_write && !stall` at cycle N: at N+1, `wb_reg_write`=1, `wb_rw`/`wb_data`/`wb_aorf` carry the captured values, and `wb_distinct` = token inverted. The token is updated to the new value.
  - Otherwise `wb_reg_write`=0, and `wb_rw`/`wb_data`/`wb_aorf`/`wb_distinct` hold their last values.
  - `ex_valid` while `stall`=1 is ignored. Upstream guarantees this does not occur.
- **RX FIFO:**
  - Pushes `rx_byte` on `rx_valid`. No fall-through: a byte pushed at N is poppable at N+1.
  - Push when full with a simultaneous pop is accepted.
  - Push when full without a pop drops the byte and sets `rx_overflow`. `rx_overflow` clears only on reset.
- **FSM** (IDLE, COLLECT, WRITE):
  - IDLE: on `in_req`, latch `in_rw` and `in_is_float`, clear the byte counter, go to COLLECT. `in_req` in any other state is ignored.
  - COLLECT: pop one byte per cycle while the FIFO is non-empty, shifting it into an assembly word. The first byte lands in [31:24], so the word is big-endian. After the 4th pop, go to WRITE. With the FIFO empty, wait in COLLECT indefinitely.
  - WRITE (one cycle):
    - `wb_uart_we`=1, `wb_distinct`=1, `wb_reg_write`=0, `wb_rw`=latched rw, `wb_aorf`=latched is_float, `wb_data`=assembled word.
    - Pulse `in_done`. Set token to 1, because the register file's buffer becomes 1.
    - Go to IDLE.
- **Simultaneous events:**
  - `ex_valid` and `in_req` in the same IDLE cycle: both are accepted. The result pulse appears at N+1 while the FSM is in COLLECT, so there is no port conflict.
  - `rx_valid` during COLLECT: push and pop in the same cycle are legal.
- **Reset mid-operation:** discards partial bytes, FIFO contents and the latched destination. No write is emitted.

## Timing
- Result latency: 1 cycle, from `ex_valid` to `wb_reg_write`.
- `in` sequence with ≥4 bytes buffered and `in_req` at N:
  - COLLECT at N+1..N+4, popping at N+1..N+4.
  - WRITE and `in_done` at N+5.
  - `stall` high N+1..N+5, low at N+6.
- Each byte arriving late extends COLLECT by the wait.
- Back-to-back results toggle `wb_distinct` every pulse.

## Structure
- Package `wb_pkg`:
  - `wb_state_t` enum {IDLE, COLLECT, WRITE}
  - `WORD_BYTES`=4
  - byte-counter width localparam
- Sub-module `rx_byte_fifo`: parameterised depth, push/pop/full/empty, with pointer wrap at `RX_DEPTH`.

## Test plan
- **Single result:** reset, then result write of `ex_rw`=5, `ex_data`=0xDEADBEEF, integer → next cycle `wb_reg_write`=1, `wb_rw`=5, `wb_data`=0xDEADBEEF, `wb_aorf`=0, `wb_distinct`=1. Three more results → `wb_distinct` 0,1,0.
- **Buffered `in`:** bytes 0x12,0x34,0x56,0x78 pushed, then `in_req` with `in_rw`=3, `in_is_float`=1 → WRITE exactly 5 cycles after `in_req` with `wb_uart_we`=1, `wb_data`=0x12345678, `wb_aorf`=1, `wb_rw`=3. The next result has `wb_distinct`=0.
- **Slow bytes:** `in_req` with FIFO empty, bytes arriving every 10 cycles → `stall` held high throughout; `in_done` 1 cycle after the 4th byte is popped.
- **Overflow:** push `RX_DEPTH`+2 bytes with no `in` → `rx_overflow`=1. The first `RX_DEPTH` bytes are retained and popped in order by subsequent `in`s.
- **Reset mid-COLLECT:** `reset` after 2 bytes popped → all outputs 0, `stall`=0. A subsequent `in` with 4 fresh bytes assembles only the fresh bytes.
- **Same-cycle events:** `in_req` and `ex_valid` in the same cycle → result pulse at N+1 and UART write later, never both in one cycle.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Bytes assembled into one UART-sourced register word
    localparam int WORD_BYTES = 4;

    // Width of the counter tracking bytes popped for the current word
    localparam int BYTE_CNT_W = $clog2(WORD_BYTES);

    // Writeback sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } wb_state_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/rx_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rx_byte_fifo
// Description : Byte FIFO for the UART receive path. No fall-through: a byte
//               written on one edge is readable after that edge. A push into
//               a full FIFO is only accepted when a pop frees a slot in the
//               same cycle; otherwise it is dropped and flagged (sticky).
// Revision    : 1.0 - initial release
// ============================================================================
module rx_byte_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_overflow;

    logic w_pop_ok;
    logic w_push_ok;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (c_PTR_W+1)'(DEPTH));
    assign o_data     = r_mem[r_rd_ptr];
    assign o_overflow = r_overflow;

    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Storage array; contents are don't-care while empty, so no reset
    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer, occupancy and overflow bookkeeping
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule : rx_byte_fifo
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit
// Description : Final pipeline stage feeding the register file write side.
//               Forwards execute results as one-cycle write pulses with a
//               toggling distinct token, and services `in` instructions by
//               assembling four buffered UART bytes (big-endian) into a word.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit
    import wb_pkg::*;
#(
    parameter int RX_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_reg_write,
    input  logic        ex_is_float,
    input  logic [4:0]  ex_rw,
    input  logic [31:0] ex_data,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        in_req,
    input  logic [4:0]  in_rw,
    input  logic        in_is_float,
    output logic        wb_reg_write,
    output logic        wb_uart_we,
    output logic        wb_distinct,
    output logic        wb_aorf,
    output logic [4:0]  wb_rw,
    output logic [31:0] wb_data,
    output logic        stall,
    output logic        in_done,
    output logic        rx_overflow
);

    wb_state_t             r_state;
    logic [4:0]            r_in_rw;
    logic                  r_in_float;
    logic [BYTE_CNT_W-1:0] r_byte_cnt;
    logic [23:0]           r_asm;
    logic                  r_token;

    logic        w_fifo_pop;
    logic [7:0]  w_fifo_data;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [31:0] w_asm_next;
    logic        w_last_pop;
    logic        w_ex_accept;

    rx_byte_fifo #(
        .DEPTH      (RX_DEPTH)
    ) u_rx_fifo (
        .CLK        (CLK),
        .reset      (reset),
        .i_push     (rx_valid),
        .i_data     (rx_byte),
        .i_pop      (w_fifo_pop),
        .o_data     (w_fifo_data),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_overflow (rx_overflow)
    );

    assign stall       = (r_state != IDLE);
    assign w_fifo_pop  = (r_state == COLLECT) && !w_fifo_empty;
    // Earlier bytes shift up, so the first byte ends in [31:24]
    assign w_asm_next  = {r_asm, w_fifo_data};
    assign w_last_pop  = w_fifo_pop && (r_byte_cnt == BYTE_CNT_W'(WORD_BYTES-1));
    assign w_ex_accept = ex_valid && ex_reg_write && !stall;

    // In-instruction sequencer: latch destination, gather bytes, then write
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= IDLE;
            r_in_rw    <= '0;
            r_in_float <= 1'b0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_req) begin
                        r_in_rw    <= in_rw;
                        r_in_float <= in_is_float;
                        r_byte_cnt <= '0;
                        r_state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (w_fifo_pop) begin
                        r_asm      <= w_asm_next[23:0];
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (w_last_pop) begin
                            r_state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Register-file write port; outputs are registered so the UART write
    // lands in the same cycle the sequencer sits in WRITE
    always_ff @(posedge CLK) begin
        if (reset) begin
            wb_reg_write <= 1'b0;
            wb_uart_we   <= 1'b0;
            wb_distinct  <= 1'b0;
            wb_aorf      <= 1'b0;
            wb_rw        <= '0;
            wb_data      <= '0;
            in_done      <= 1'b0;
            r_token      <= 1'b0;
        end else begin
            wb_reg_write <= 1'b0;
            wb_uart_we   <= 1'b0;
            in_done      <= 1'b0;
            if (w_last_pop) begin
                // Register file buffer becomes 1 after a UART write
                wb_uart_we  <= 1'b1;
                wb_distinct <= 1'b1;
                wb_aorf     <= r_in_float;
                wb_rw       <= r_in_rw;
                wb_data     <= w_asm_next;
                in_done     <= 1'b1;
                r_token     <= 1'b1;
            end else if (w_ex_accept) begin
                wb_reg_write <= 1'b1;
                wb_distinct  <= ~r_token;
                wb_aorf      <= ex_is_float;
                wb_rw        <= ex_rw;
                wb_data      <= ex_data;
                r_token      <= ~r_token;
            end
        end
    end

endmodule : writeback_unit
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_unit
// Description : Scoreboard bench for writeback_unit. Expected writes are
//               queued as stimulus is driven and compared as the DUT emits
//               write pulses; timing and flags are checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;

    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        reset;
    logic        ex_valid, ex_reg_write, ex_is_float;
    logic [4:0]  ex_rw;
    logic [31:0] ex_data;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        in_req;
    logic [4:0]  in_rw;
    logic        in_is_float;
    logic        wb_reg_write, wb_uart_we, wb_distinct, wb_aorf;
    logic [4:0]  wb_rw;
    logic [31:0] wb_data;
    logic        stall, in_done, rx_overflow;

    int checks   = 0;
    int failures = 0;

    logic [40:0] sb_q [$];
    logic [7:0]  mq   [$];
    logic        tok;
    logic [40:0] w_obs;

    assign w_obs = {wb_reg_write, wb_uart_we, wb_distinct, wb_aorf, wb_rw, wb_data};

    always #5 CLK = ~CLK;

    writeback_unit #(.RX_DEPTH(DEPTH)) dut (
        .CLK(CLK), .reset(reset),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_is_float(ex_is_float),
        .ex_rw(ex_rw), .ex_data(ex_data),
        .rx_valid(rx_valid), .rx_byte(rx_byte),
        .in_req(in_req), .in_rw(in_rw), .in_is_float(in_is_float),
        .wb_reg_write(wb_reg_write), .wb_uart_we(wb_uart_we), .wb_distinct(wb_distinct),
        .wb_aorf(wb_aorf), .wb_rw(wb_rw), .wb_data(wb_data),
        .stall(stall), .in_done(in_done), .rx_overflow(rx_overflow)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the oldest queued expectation
    always @(negedge CLK) begin
        if (!reset && (wb_reg_write || wb_uart_we)) begin
            check_eq("single_write_port", 64'(wb_reg_write & wb_uart_we), 64'd0);
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_write", 64'(w_obs), 64'd0);
            end else begin
                check_eq("sb_write", 64'(w_obs), 64'(sb_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ex_valid = 0; ex_reg_write = 0; ex_is_float = 0; ex_rw = '0; ex_data = '0;
        rx_valid = 0; rx_byte = '0; in_req = 0; in_rw = '0; in_is_float = 0;
        tick(); tick(); tick();
        mq.delete();
        sb_q.delete();
        tok = 1'b0;
        reset = 1'b0;
    endtask

    task automatic send_result(input logic [4:0] rw, input logic [31:0] d,
                               input logic isf, input logic regw);
        ex_valid = 1; ex_reg_write = regw; ex_is_float = isf; ex_rw = rw; ex_data = d;
        if (regw) begin
            sb_q.push_back({1'b1, 1'b0, ~tok, isf, rw, d});
            tok = ~tok;
        end
        tick();
        ex_valid = 0; ex_reg_write = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1; rx_byte = b;
        if (mq.size() < DEPTH) mq.push_back(b);
        tick();
        rx_valid = 0;
    endtask

    task automatic expect_in(input logic [4:0] rw, input logic isf);
        logic [31:0] w;
        w = '0;
        check_eq("model_bytes_avail", 64'(mq.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (mq.size() > 0) w = {w[23:0], mq.pop_front()};
        end
        sb_q.push_back({1'b0, 1'b1, 1'b1, isf, rw, w});
        tok = 1'b1;
    endtask

    // Issue `in` with bytes already buffered (optionally a result in the same cycle)
    task automatic run_in(input logic [4:0] rw, input logic isf, input logic with_ex);
        int n;
        int low;
        low = 0;
        if (with_ex) begin
            ex_valid = 1; ex_reg_write = 1; ex_is_float = 0; ex_rw = 5'd6; ex_data = 32'h0000600D;
            sb_q.push_back({1'b1, 1'b0, ~tok, 1'b0, 5'd6, 32'h0000600D});
            tok = ~tok;
        end
        expect_in(rw, isf);
        in_req = 1; in_rw = rw; in_is_float = isf;
        for (n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) begin
                in_req = 0; ex_valid = 0; ex_reg_write = 0;
            end
            if (!stall) low++;
            if (in_done) break;
        end
        check_eq("in_latency", 64'(n), 64'd5);
        check_eq("in_stall_held", 64'(low), 64'd0);
        tick();
        check_eq("in_stall_release", 64'(stall), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int low;
        int done_seen;
        do_reset();
        check_eq("reset_outputs", 64'(w_obs), 64'd0);
        check_eq("reset_flags", 64'({stall, in_done, rx_overflow}), 64'd0);

        // Single result then three more; distinct toggles 1,0,1,0
        send_result(5'd5, 32'hDEADBEEF, 1'b0, 1'b1);
        check_eq("first_distinct", 64'(wb_distinct), 64'd1);
        check_eq("first_data", 64'(wb_data), 64'hDEADBEEF);
        send_result(5'd1, 32'hCAFE0002, 1'b0, 1'b1);
        send_result(5'd2, 32'hCAFE0003, 1'b1, 1'b1);
        send_result(5'd31, 32'hCAFE0004, 1'b1, 1'b1);
        check_eq("fourth_distinct", 64'(wb_distinct), 64'd0);
        send_result(5'd7, 32'h11111111, 1'b0, 1'b0);
        check_eq("hold_no_write", 64'(wb_reg_write), 64'd0);
        check_eq("hold_data", 64'(wb_data), 64'hCAFE0004);

        // Buffered in, then next result must carry distinct 0
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        run_in(5'd3, 1'b1, 1'b0);
        send_result(5'd9, 32'h0BADF00D, 1'b0, 1'b1);
        check_eq("post_in_distinct", 64'(wb_distinct), 64'd0);

        // Slow bytes: in_req with FIFO empty, bytes every 10 cycles
        in_req = 1; in_rw = 5'd12; in_is_float = 0;
        tick();
        in_req = 0;
        low = 0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 10; j++) begin
                tick();
                if (!stall) low++;
            end
            send_byte(8'hC0 + 8'(k));
        end
        expect_in(5'd12, 1'b0);
        check_eq("slow_done_early", 64'(in_done), 64'd0);
        tick();
        check_eq("slow_done", 64'(in_done), 64'd1);
        check_eq("slow_stall_held", 64'(low), 64'd0);
        tick();
        check_eq("slow_stall_release", 64'(stall), 64'd0);

        // Overflow: DEPTH+2 bytes, first DEPTH retained in order
        do_reset();
        check_eq("overflow_clear", 64'(rx_overflow), 64'd0);
        for (int i = 0; i < DEPTH + 2; i++) send_byte(8'hA0 + 8'(i));
        check_eq("overflow_set", 64'(rx_overflow), 64'd1);
        run_in(5'd1, 1'b0, 1'b0);
        run_in(5'd2, 1'b1, 1'b0);
        in_req = 1; in_rw = 5'd8; in_is_float = 0;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            in_req = 0;
            if (in_done) done_seen++;
        end
        check_eq("dropped_bytes_absent", 64'(done_seen), 64'd0);
        check_eq("overflow_sticky", 64'(rx_overflow), 64'd1);

        // Reset mid-COLLECT after two bytes popped
        send_byte(8'h11); send_byte(8'h22);
        tick();
        do_reset();
        check_eq("midreset_outputs", 64'(w_obs), 64'd0);
        check_eq("midreset_flags", 64'({stall, in_done, rx_overflow}), 64'd0);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        run_in(5'd4, 1'b0, 1'b0);

        // Result and in_req in the same IDLE cycle
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        run_in(5'd7, 1'b0, 1'b1);

        tick(); tick();
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_writeback_unit
`default_nettype wire
